// File: rtl/alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : alu                                                               |
// | Purpose  : RV32I integer ALU, registered result (one-cycle latency).         |
// |            Optional zero flag output when ALU_ZERO_FLAG_EN is defined.       |
// | Revision : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module alu #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_in_a,
   input  logic [XLEN-1:0] i_in_b,
   input  logic [2:0]      i_funct3,
   input  logic            i_funct7_4,
   input  logic            i_alu_en,
   input  logic            i_alu_imm,
`ifdef ALU_ZERO_FLAG_EN
   output logic            o_alu_zero,
`endif
   output logic [XLEN-1:0] o_alu_out
);

   localparam int         C_SHAMT_W = $clog2(XLEN);

   localparam logic [2:0] C_F3_ADD  = 3'd0;
   localparam logic [2:0] C_F3_SLL  = 3'd1;
   localparam logic [2:0] C_F3_SLT  = 3'd2;
   localparam logic [2:0] C_F3_SLTU = 3'd3;
   localparam logic [2:0] C_F3_XOR  = 3'd4;
   localparam logic [2:0] C_F3_SR   = 3'd5;
   localparam logic [2:0] C_F3_OR   = 3'd6;
   localparam logic [2:0] C_F3_AND  = 3'd7;

   logic [C_SHAMT_W-1:0] w_shamt;
   logic [XLEN-1:0]      w_result;
   logic [XLEN-1:0]      r_alu_out;

   assign w_shamt = i_in_b[C_SHAMT_W-1:0];

   always_comb begin
      w_result = i_in_a + i_in_b;
      if (i_alu_en) begin
         unique case (i_funct3)
            // Bit 30 of an ADDI is part of the immediate, so it never selects SUB.
            C_F3_ADD:  w_result = (i_funct7_4 && !i_alu_imm) ? (i_in_a - i_in_b)
                                                             : (i_in_a + i_in_b);
            C_F3_SLL:  w_result = i_in_a << w_shamt;
            C_F3_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(i_in_a) < $signed(i_in_b))};
            C_F3_SLTU: w_result = {{(XLEN-1){1'b0}}, (i_in_a < i_in_b)};
            C_F3_XOR:  w_result = i_in_a ^ i_in_b;
            C_F3_SR:   w_result = i_funct7_4 ? XLEN'($signed(i_in_a) >>> w_shamt)
                                             : (i_in_a >> w_shamt);
            C_F3_OR:   w_result = i_in_a | i_in_b;
            C_F3_AND:  w_result = i_in_a & i_in_b;
            default:   w_result = i_in_a + i_in_b;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_alu_out <= '0;
      end else begin
         r_alu_out <= w_result;
      end
   end

   assign o_alu_out = r_alu_out;

`ifdef ALU_ZERO_FLAG_EN
   logic r_alu_zero;

   // Reset value 1 mirrors the cleared result register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_alu_zero <= 1'b1;
      end else begin
         r_alu_zero <= (w_result == '0);
      end
   end

   assign o_alu_zero = r_alu_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// Self-checking testbench for alu: directed vectors with hand-computed results.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  funct3;
   logic        funct7_4;
   logic        alu_en;
   logic        alu_imm;
   logic [31:0] alu_out;
`ifdef ALU_ZERO_FLAG_EN
   logic        alu_zero;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   alu #(.XLEN(32)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_in_a     (in_a),
      .i_in_b     (in_b),
      .i_funct3   (funct3),
      .i_funct7_4 (funct7_4),
      .i_alu_en   (alu_en),
      .i_alu_imm  (alu_imm),
`ifdef ALU_ZERO_FLAG_EN
      .o_alu_zero (alu_zero),
`endif
      .o_alu_out  (alu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a vector after the falling edge, let one rising edge capture it,
   // then sample #1 later.
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic f7, input logic en, input logic imm);
      @(negedge clk);
      in_a = a; in_b = b; funct3 = f3; funct7_4 = f7; alu_en = en; alu_imm = imm;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      in_a = 32'h12345678; in_b = 32'h1; funct3 = 3'd0; funct7_4 = 1'b0;
      alu_en = 1'b1; alu_imm = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (alu_out !== 32'h0) $display("FAIL reset_out: got %h expected %h", alu_out, 32'h0);
      else pass_cnt++;
`ifdef ALU_ZERO_FLAG_EN
      total_cnt++;
      if (alu_zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", alu_zero);
      else pass_cnt++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (alu_out !== 32'h12345679) $display("FAIL reset_release: got %h expected %h", alu_out, 32'h12345679);
      else pass_cnt++;
   endtask

   task automatic test_add_sub;
      logic [31:0] a   [6] = '{32'h3, 32'hFFFFFFFF, 32'h3,        32'h0,        32'h3, 32'h0};
      logic [31:0] b   [6] = '{32'h7, 32'h1,        32'h7,        32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF};
      logic        f7  [6] = '{1'b0,  1'b0,         1'b1,         1'b1,         1'b1,  1'b1};
      logic        imm [6] = '{1'b0,  1'b0,         1'b0,         1'b0,         1'b1,  1'b1};
      logic [31:0] exp [6] = '{32'hA, 32'h0,        32'hFFFFFFFC, 32'h1,        32'hA, 32'hFFFFFFFF};
      for (int i = 0; i < 6; i++) begin
         apply(a[i], b[i], 3'd0, f7[i], 1'b1, imm[i]);
         total_cnt++;
         if (alu_out !== exp[i]) $display("FAIL add_sub[%0d]: got %h expected %h", i, alu_out, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_shifts;
      logic [31:0] a   [10] = '{32'h21212121, 32'h21212121, 32'h21212121, 32'h80000001, 32'h80000001,
                                32'h80000001, 32'h80000001, 32'h40000001, 32'h21212121, 32'h80000001};
      logic [31:0] b   [10] = '{32'd1, 32'd14, 32'd31, 32'd1, 32'd31,
                                32'd1, 32'd30, 32'd30, 32'h2E, 32'h0};
      logic [2:0]  f3  [10] = '{3'd1, 3'd1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 3'd5};
      logic        f7  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp [10] = '{32'h42424242, 32'h48484000, 32'h80000000, 32'h40000000, 32'h00000001,
                                32'hC0000000, 32'hFFFFFFFE, 32'h00000001, 32'h48484000, 32'h80000001};
      for (int i = 0; i < 10; i++) begin
         // Odd entries use the immediate form; funct7_4 must still pick SRA.
         apply(a[i], b[i], f3[i], f7[i], 1'b1, 1'(i % 2));
         total_cnt++;
         if (alu_out !== exp[i]) $display("FAIL shift[%0d]: got %h expected %h", i, alu_out, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_compares;
      logic [31:0] a   [6] = '{32'h80000001, 32'hFFFFFFFF, 32'h7, 32'h80000000, 32'h1, 32'hFFFFFFFF};
      logic [31:0] b   [6] = '{32'h1,        32'h7FFFFFFF, 32'h3, 32'h1,        32'h3, 32'h7FFFFFFF};
      logic [2:0]  f3  [6] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
      logic [31:0] exp [6] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
      for (int i = 0; i < 6; i++) begin
         apply(a[i], b[i], f3[i], 1'b0, 1'b1, 1'b0);
         total_cnt++;
         if (alu_out !== exp[i]) $display("FAIL compare[%0d]: got %h expected %h", i, alu_out, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_logic;
      logic [31:0] a   [3] = '{32'hFF00FF00, 32'h00FF00FF, 32'hF00FF00F};
      logic [31:0] b   [3] = '{32'hF00FF00F, 32'h0F0F0F0F, 32'hF0F0F0F0};
      logic [2:0]  f3  [3] = '{3'd4, 3'd6, 3'd7};
      logic [31:0] exp [3] = '{32'h0F0F0F0F, 32'h0FFF0FFF, 32'hF000F000};
      for (int i = 0; i < 3; i++) begin
         apply(a[i], b[i], f3[i], 1'b1, 1'b1, 1'b0);
         total_cnt++;
         if (alu_out !== exp[i]) $display("FAIL logic[%0d]: got %h expected %h", i, alu_out, exp[i]);
         else pass_cnt++;
      end
   endtask

   // Back-to-back vectors with ALU disabled: output must still hold the
   // previous result before the edge and show the new one right after it.
   task automatic test_back_to_back;
      logic [31:0] a   [4] = '{32'h1, 32'h3, 32'h0,        32'h0};
      logic [31:0] b   [4] = '{32'h1, 32'h7, 32'hFFFF8000, 32'h0};
      logic [31:0] exp [4] = '{32'h2, 32'hA, 32'hFFFF8000, 32'h0};
      logic [31:0] prev;
      prev = alu_out;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_a = a[i]; in_b = b[i]; funct3 = 3'd7; funct7_4 = 1'b1; alu_en = 1'b0; alu_imm = 1'b1;
         #1;
         total_cnt++;
         if (alu_out !== prev) $display("FAIL disabled_hold[%0d]: got %h expected %h", i, alu_out, prev);
         else pass_cnt++;
         @(posedge clk);
         #1;
         total_cnt++;
         if (alu_out !== exp[i]) $display("FAIL disabled_add[%0d]: got %h expected %h", i, alu_out, exp[i]);
         else pass_cnt++;
`ifdef ALU_ZERO_FLAG_EN
         total_cnt++;
         if (alu_zero !== (i == 3)) $display("FAIL zero_flag[%0d]: got %b expected %b", i, alu_zero, (i == 3));
         else pass_cnt++;
`endif
         prev = exp[i];
      end
   endtask

   task automatic test_wrap;
      apply(32'h1, 32'h7FFFFFFF, 3'd0, 1'b0, 1'b1, 1'b0);
      total_cnt++;
      if (alu_out !== 32'h80000000) $display("FAIL wrap_pos: got %h expected %h", alu_out, 32'h80000000);
      else pass_cnt++;
      apply(32'hFFFF8000, 32'h80000000, 3'd0, 1'b0, 1'b1, 1'b1);
      total_cnt++;
      if (alu_out !== 32'h7FFF8000) $display("FAIL wrap_neg: got %h expected %h", alu_out, 32'h7FFF8000);
      else pass_cnt++;
      // Reset must win over live operands mid-run.
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total_cnt++;
      if (alu_out !== 32'h0) $display("FAIL reset_midrun: got %h expected %h", alu_out, 32'h0);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_a = '0; in_b = '0; funct3 = '0;
      funct7_4 = 1'b0; alu_en = 1'b0; alu_imm = 1'b0;
      test_reset();
      test_add_sub();
      test_shifts();
      test_compares();
      test_logic();
      test_back_to_back();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
